// File: rtl/lifo_stack_if.sv
// Handshake and status bundle between a stack client (master) and lifo_stack (slave).
// Width parameters must match the ones given to the lifo_stack instance.
interface lifo_stack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic                  flush;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] top_data;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, push_data, pop, flush, err_clr,
        input  top_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, flush, err_clr,
        output top_data, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack: all DEPTH entries usable, same-cycle push+pop replaces the top,
// flush, occupancy count and sticky overflow/underflow flags. Top-of-stack is combinational.
module lifo_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    lifo_stack_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic                  wr_en_s;
    logic [AW-1:0]         wr_idx_s;
    logic [AW-1:0]         top_idx_s;
    logic                  empty_s;
    logic                  full_s;

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign top_idx_s = AW'(count_r - ONE_C);

    // Next-state decode: flush wins over push/pop; a failed pop on empty still lets a push land.
    always_comb begin
        count_nxt_s = count_r;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = AW'(count_r);
        if (bus.flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        wr_en_s     = 1'b1;
                        count_nxt_s = count_r + ONE_C;
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        count_nxt_s = count_r - ONE_C;
                    end
                end
                2'b11: begin
                    wr_en_s = 1'b1;
                    if (empty_s) begin
                        unf_set_s   = 1'b1;
                        wr_idx_s    = {AW{1'b0}};
                        count_nxt_s = ONE_C;
                    end else begin
                        wr_idx_s = top_idx_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Occupancy and sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ovf_r   <= ovf_set_s | (ovf_r & ~bus.err_clr);
            unf_r   <= unf_set_s | (unf_r & ~bus.err_clr);
        end
    end

    // Storage is deliberately not reset; it is only ever exposed through a nonzero count.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= bus.push_data;
        end
    end

    assign bus.top_data  = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[top_idx_s];
    assign bus.count     = count_r;
    assign bus.empty     = empty_s;
    assign bus.full      = full_s;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: a DEPTH=4 instance and a default-parameter instance share one
// stimulus stream; each is compared every cycle with an array-based stack model.
module tb_lifo_stack;
    logic       clk;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       flush;
    logic       err_clr;

    int checks;
    int failures;

    logic [7:0] m_stk [2][256];
    int         m_cnt [2];
    bit         m_ovf [2];
    bit         m_unf [2];

    lifo_stack_if #(.DATA_WIDTH(8), .DEPTH(4)) b4 ();
    lifo_stack_if                              b256 ();

    assign b4.push        = push;
    assign b4.push_data   = push_data;
    assign b4.pop         = pop;
    assign b4.flush       = flush;
    assign b4.err_clr     = err_clr;
    assign b256.push      = push;
    assign b256.push_data = push_data;
    assign b256.pop       = pop;
    assign b256.flush     = flush;
    assign b256.err_clr   = err_clr;

    lifo_stack #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    lifo_stack                              dut256 (.clk(clk), .rst_n(rst_n), .bus(b256));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cap_of(input int i);
        return (i == 0) ? 4 : 256;
    endfunction

    function automatic logic [7:0] exp_top(input int i);
        return (m_cnt[i] == 0) ? 8'h00 : m_stk[i][m_cnt[i]-1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endtask

    // Apply one clock edge of the current inputs to the stack model.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit so = 1'b0;
            bit su = 1'b0;
            if (flush) begin
                m_cnt[i] = 0;
            end else if (push && pop && m_cnt[i] > 0) begin
                m_stk[i][m_cnt[i]-1] = push_data;
            end else begin
                if (pop) begin
                    if (m_cnt[i] > 0) m_cnt[i]--;
                    else su = 1'b1;
                end
                if (push) begin
                    if (m_cnt[i] < cap_of(i)) begin
                        m_stk[i][m_cnt[i]] = push_data;
                        m_cnt[i]++;
                    end else begin
                        so = 1'b1;
                    end
                end
            end
            m_ovf[i] = so | (m_ovf[i] & !err_clr);
            m_unf[i] = su | (m_unf[i] & !err_clr);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("d4_top",   32'(b4.top_data),    32'(exp_top(0)));
        chk("d4_count", 32'(b4.count),       32'(m_cnt[0]));
        chk("d4_empty", 32'(b4.empty),       32'(m_cnt[0] == 0));
        chk("d4_full",  32'(b4.full),        32'(m_cnt[0] == 4));
        chk("d4_ovf",   32'(b4.overflow),    32'(m_ovf[0]));
        chk("d4_unf",   32'(b4.underflow),   32'(m_unf[0]));
        chk("dd_top",   32'(b256.top_data),  32'(exp_top(1)));
        chk("dd_count", 32'(b256.count),     32'(m_cnt[1]));
        chk("dd_empty", 32'(b256.empty),     32'(m_cnt[1] == 0));
        chk("dd_full",  32'(b256.full),      32'(m_cnt[1] == 256));
        chk("dd_ovf",   32'(b256.overflow),  32'(m_ovf[1]));
        chk("dd_unf",   32'(b256.underflow), 32'(m_unf[1]));
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic o,
                         input logic f, input logic e);
        push      = p;
        push_data = d;
        pop       = o;
        flush     = f;
        err_clr   = e;
    endtask

    // One clock: edge, model step, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic step(input logic p, input logic [7:0] d, input logic o,
                        input logic f, input logic e);
        drive(p, d, o, f, e);
        tick();
    endtask

    initial begin
        logic [7:0] vals [4];
        checks   = 0;
        failures = 0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(b4.count), 32'd0);
        chk("rst_empty", 32'(b4.empty), 32'd1);
        chk("rst_full",  32'(b4.full),  32'd0);
        chk("rst_top",   32'(b4.top_data), 32'h00);
        chk("rst_flags", {30'd0, b4.overflow, b4.underflow}, 32'd0);
        rst_n = 1'b1;

        // 1: fill, then pop all, sampling top_data while pop is asserted
        for (int k = 0; k < 4; k++) step(1'b1, vals[k], 1'b0, 1'b0, 1'b0);
        chk("t1_full",  32'(b4.full),     32'd1);
        chk("t1_count", 32'(b4.count),    32'd4);
        chk("t1_top",   32'(b4.top_data), 32'h44);
        chk("t1_ovf",   32'(b4.overflow), 32'd0);
        for (int k = 3; k >= 0; k--) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            chk("t1_popdata", 32'(b4.top_data), 32'(vals[k]));
            tick();
        end
        chk("t1_empty", 32'(b4.empty),    32'd1);
        chk("t1_top0",  32'(b4.top_data), 32'h00);

        // 2: push while full, then clear overflow
        for (int k = 0; k < 4; k++) step(1'b1, vals[k], 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("t2_count", 32'(b4.count),    32'd4);
        chk("t2_top",   32'(b4.top_data), 32'h44);
        chk("t2_ovf",   32'(b4.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t2_clr",   32'(b4.overflow), 32'd0);

        // 3: underflow, push+pop on empty, err_clr losing to a new underflow
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t3_unf",   32'(b4.underflow), 32'd1);
        chk("t3_cnt0",  32'(b4.count),     32'd0);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t3_cnt1",  32'(b4.count),     32'd1);
        chk("t3_top",   32'(b4.top_data),  32'hA5);
        chk("t3_unf1",  32'(b4.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("t3_setwin", 32'(b4.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3_clr",   32'(b4.underflow), 32'd0);

        // 4: replace top at count=2 and at full
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("t4_cnt2",  32'(b4.count),    32'd2);
        chk("t4_top99", 32'(b4.top_data), 32'h99);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("t4_cnt4",  32'(b4.count),    32'd4);
        chk("t4_top77", 32'(b4.top_data), 32'h77);
        chk("t4_ovf",   32'(b4.overflow), 32'd0);

        // 5: flush beats push, flags survive the flush
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_cnt3",  32'(b4.count),    32'd3);
        step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        chk("t5_cnt0",  32'(b4.count),    32'd0);
        chk("t5_empty", 32'(b4.empty),    32'd1);
        chk("t5_top",   32'(b4.top_data), 32'h00);
        chk("t5_ovf",   32'(b4.overflow), 32'd1);

        // 6: asynchronous reset between edges during a push
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_cnt",   32'(b4.count),     32'd0);
        chk("t6_ovf",   32'(b4.overflow),  32'd0);
        chk("t6_unf",   32'(b4.underflow), 32'd0);
        chk("t6_empty", 32'(b4.empty),     32'd1);
        check_all();
        tick();
        rst_n = 1'b1;
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("t6_top",   32'(b4.top_data),  32'h01);

        // Fill past both capacities so the default instance also hits full/overflow.
        for (int k = 0; k < 260; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(b256.full), 32'd1);
        chk("fill_ovf",  32'(b256.overflow), 32'd1);

        // Randomised traffic, push-biased then pop-biased.
        for (int k = 0; k < 800; k++) begin
            int pp = (k < 400) ? 6 : 3;
            step(($urandom_range(0, 9) < pp), 8'($urandom),
                 ($urandom_range(0, 9) < 9 - pp),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
